pipe_perf_monitor: RTL and testbench

- Synthesisable, parametrised performance monitor for the pipelined CPU.
- Replaces bench-side stall/flush counting and the fixed "stop after N cycles" logic.
- Counts run cycles plus NUM_EVT per-channel hazard events (stall, flush, load-use, etc.) and raises done_o at a programmable cycle limit.
- Counter values are read back through a registered request/valid port. The block sits beside the CPU top level, with its event inputs driven by hazard-detection and control signals.

---
 rtl/pipe_perf_monitor.sv | 107 ++++++++++
 tb/tb_pipe_perf_monitor.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_perf_monitor.sv
// Pipeline performance monitor: cycle and per-channel hazard event counters
// with a programmable run limit and a registered readout port.
module pipe_perf_monitor #(
    parameter int NUM_EVT = 4,
    parameter int CNT_W   = 32,
    parameter int SEL_W   = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               clear_i,
    input  logic [NUM_EVT-1:0] evt_i,
    input  logic [CNT_W-1:0]   limit_i,
    input  logic               rd_req_i,
    input  logic [SEL_W-1:0]   rd_sel_i,
    output logic               rd_valid_o,
    output logic [CNT_W-1:0]   rd_data_o,
    output logic [CNT_W-1:0]   cycle_o,
    output logic               done_o,
    output logic [NUM_EVT:0]   ovf_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cyc;
    logic [CNT_W-1:0] cyc_inc;
    logic             cyc_sat;
    logic [CNT_W-1:0] cnt [NUM_EVT];
    logic [NUM_EVT:0] ovf;
    logic [CNT_W-1:0] rd_mux;
    logic             counting;

    assign counting = (state == RUN) && start_i;
    assign cyc_sat  = &cyc;
    assign cyc_inc  = cyc_sat ? cyc : cyc + CNT_W'(1);

    // The limit match uses the post-increment value, so a lowered limit never matches retroactively
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (start_i) state_nxt = RUN;
            RUN: begin
                if (start_i && (limit_i != '0) && (cyc_inc == limit_i))
                    state_nxt = DONE;
            end
            DONE: state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
        if (clear_i) state_nxt = IDLE;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cyc <= '0;
            ovf <= '0;
            for (int k = 0; k < NUM_EVT; k++) cnt[k] <= '0;
        end else if (clear_i) begin
            cyc <= '0;
            ovf <= '0;
            for (int k = 0; k < NUM_EVT; k++) cnt[k] <= '0;
        end else if (counting) begin
            cyc <= cyc_inc;
            if (cyc_sat) ovf[0] <= 1'b1;
            for (int k = 0; k < NUM_EVT; k++) begin
                if (evt_i[k]) begin
                    if (&cnt[k]) ovf[k+1] <= 1'b1;
                    else         cnt[k]   <= cnt[k] + CNT_W'(1);
                end
            end
        end
    end

    // Selects beyond the last channel read as zero
    always_comb begin
        rd_mux = '0;
        if (rd_sel_i == '0) rd_mux = cyc;
        for (int k = 0; k < NUM_EVT; k++) begin
            if (rd_sel_i == SEL_W'(k + 1)) rd_mux = cnt[k];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_valid_o <= 1'b0;
            rd_data_o  <= '0;
        end else begin
            rd_valid_o <= rd_req_i;
            if (rd_req_i) rd_data_o <= rd_mux;
        end
    end

    assign cycle_o = cyc;
    assign done_o  = (state == DONE);
    assign ovf_o   = ovf;

endmodule

// File: tb/tb_pipe_perf_monitor.sv
// Scoreboard bench for pipe_perf_monitor: directed scenarios plus randomized
// traffic checked against a behavioural model.
module tb_pipe_perf_monitor;

    localparam int NEVT = 4;
    localparam int CW   = 8;
    localparam int SW   = 3;
    localparam longint MAXV = (64'd1 << CW) - 1;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            start = 1'b0;
    logic            clear = 1'b0;
    logic [NEVT-1:0] evt = '0;
    logic [CW-1:0]   limit = '0;
    logic            rd_req = 1'b0;
    logic [SW-1:0]   rd_sel = '0;
    logic            rd_valid;
    logic [CW-1:0]   rd_data;
    logic [CW-1:0]   cycle;
    logic            done;
    logic [NEVT:0]   ovf;

    logic [3:0]      s_limit = '0;
    logic            s_rd_valid;
    logic [3:0]      s_rd_data;
    logic [3:0]      s_cycle;
    logic            s_done;
    logic [1:0]      s_ovf;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    pipe_perf_monitor #(.NUM_EVT(NEVT), .CNT_W(CW), .SEL_W(SW)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear),
        .evt_i(evt), .limit_i(limit), .rd_req_i(rd_req), .rd_sel_i(rd_sel),
        .rd_valid_o(rd_valid), .rd_data_o(rd_data), .cycle_o(cycle),
        .done_o(done), .ovf_o(ovf)
    );

    pipe_perf_monitor #(.NUM_EVT(1), .CNT_W(4), .SEL_W(1)) dut_s (
        .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear),
        .evt_i(evt[0:0]), .limit_i(s_limit), .rd_req_i(rd_req),
        .rd_sel_i(rd_sel[0:0]), .rd_valid_o(s_rd_valid),
        .rd_data_o(s_rd_data), .cycle_o(s_cycle), .done_o(s_done),
        .ovf_o(s_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural reference model
    typedef enum {M_IDLE, M_RUN, M_DONE} mode_t;
    mode_t       m_mode = M_IDLE;
    longint      m_cyc = 0;
    longint      m_evt [NEVT];
    logic [NEVT:0] m_ovf = '0;
    longint      rd_q[$];

    function automatic longint bump(input longint v, inout logic flag);
        if (v >= MAXV) begin
            flag = 1'b1;
            return MAXV;
        end
        return v + 1;
    endfunction

    task automatic model_zero();
        m_mode = M_IDLE;
        m_cyc  = 0;
        m_ovf  = '0;
        foreach (m_evt[k]) m_evt[k] = 0;
    endtask

    initial foreach (m_evt[k]) m_evt[k] = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_zero();
            rd_q.delete();
        end else begin
            if (rd_req) begin
                if (rd_sel == 0)          rd_q.push_back(m_cyc);
                else if (rd_sel <= NEVT)  rd_q.push_back(m_evt[rd_sel-1]);
                else                      rd_q.push_back(0);
            end
            if (clear) begin
                model_zero();
            end else if (m_mode == M_IDLE) begin
                if (start) m_mode = M_RUN;
            end else if (m_mode == M_RUN && start) begin
                logic f;
                f = m_ovf[0];
                m_cyc = bump(m_cyc, f);
                m_ovf[0] = f;
                for (int k = 0; k < NEVT; k++) begin
                    if (evt[k]) begin
                        f = m_ovf[k+1];
                        m_evt[k] = bump(m_evt[k], f);
                        m_ovf[k+1] = f;
                    end
                end
                if (limit != 0 && m_cyc == limit) m_mode = M_DONE;
            end
        end
    end

    // Monitor: pops the scoreboard whenever a readout is due
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (rd_q.size() > 0) begin
                longint e;
                e = rd_q.pop_front();
                chk("rd_valid", rd_valid, 1);
                chk("rd_data", rd_data, e);
            end else begin
                chk("rd_valid_idle", rd_valid, 0);
            end
            chk("cycle_o", cycle, m_cyc);
            chk("done_o", done, m_mode == M_DONE);
            chk("ovf_o", ovf, m_ovf);
        end
    end

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #1 rst = 1'b1;
        #1;
        chk("por_cycle", cycle, 0);
        chk("por_done", done, 0);
        chk("por_valid", rd_valid, 0);
        #10 rst = 1'b0;
        mon_en = 1'b1;

        // Reset mid-run after 7 counted cycles
        start = 1'b1;
        tick();
        rd_req = 1'b1;
        rd_sel = 0;
        repeat (7) tick();
        rd_req = 1'b0;
        chk("pre_rst_cycle", cycle, 7);
        chk("pre_rst_rdata", rd_data, 6);
        rst = 1'b1;
        #1;
        chk("async_rst_cycle", cycle, 0);
        chk("async_rst_done", done, 0);
        chk("async_rst_ovf", ovf, 0);
        chk("async_rst_valid", rd_valid, 0);
        chk("async_rst_rdata", rd_data, 0);
        rst = 1'b0;
        tick();
        chk("restart_edge1", cycle, 0);
        tick();
        chk("restart_edge2", cycle, 1);

        // Limit 30
        clear = 1'b1;
        start = 1'b0;
        tick();
        clear = 1'b0;
        limit = 30;
        start = 1'b1;
        repeat (30) tick();
        chk("limit_pre_done", done, 0);
        chk("limit_pre_cycle", cycle, 29);
        tick();
        chk("limit_done", done, 1);
        chk("limit_cycle", cycle, 30);
        repeat (3) tick();
        chk("limit_frozen", cycle, 30);

        // Clear and start together in DONE
        clear = 1'b1;
        tick();
        chk("clr_done", done, 0);
        chk("clr_cycle", cycle, 0);
        clear = 1'b0;
        limit = 0;
        start = 1'b0;
        repeat (2) tick();
        start = 1'b1;
        tick();
        chk("clr_idle_entry", cycle, 0);
        tick();
        chk("clr_first_count", cycle, 1);

        // Events and pause
        clear = 1'b1;
        start = 1'b0;
        tick();
        clear = 1'b0;
        start = 1'b1;
        tick();
        evt = 4'b0011;
        repeat (3) tick();
        evt = 4'b0001;
        repeat (2) tick();
        chk("evt_cycle", cycle, 5);
        start = 1'b0;
        evt = 4'b1111;
        repeat (4) begin
            tick();
            chk("pause_cycle", cycle, 5);
        end
        evt = '0;
        rd_req = 1'b1;
        rd_sel = 1;
        tick();
        chk("evt0_read", rd_data, 5);
        rd_sel = 2;
        tick();
        chk("evt1_read", rd_data, 3);
        rd_req = 1'b0;

        // Read colliding with clear, then out-of-range select
        clear = 1'b1;
        tick();
        clear = 1'b0;
        start = 1'b1;
        repeat (13) tick();
        start = 1'b0;
        chk("coll_pre", cycle, 12);
        rd_req = 1'b1;
        rd_sel = 0;
        clear = 1'b1;
        tick();
        chk("coll_rdata", rd_data, 12);
        chk("coll_valid", rd_valid, 1);
        chk("coll_cycle", cycle, 0);
        clear = 1'b0;
        rd_sel = NEVT + 1;
        tick();
        chk("oor_rdata", rd_data, 0);
        chk("oor_valid", rd_valid, 1);
        rd_req = 1'b0;
        tick();
        chk("hold_valid", rd_valid, 0);
        chk("hold_rdata", rd_data, 0);

        // Saturation (4-bit instance after 20 counts, 8-bit after 302)
        clear = 1'b1;
        tick();
        clear = 1'b0;
        start = 1'b1;
        evt = 4'b0001;
        tick();
        repeat (20) tick();
        rd_req = 1'b1;
        rd_sel = 1;
        tick();
        rd_req = 1'b0;
        chk("s_sat_read", s_rd_data, 15);
        chk("s_sat_valid", s_rd_valid, 1);
        chk("s_sat_cycle", s_cycle, 15);
        chk("s_sat_ovf", s_ovf, 3);
        repeat (280) tick();
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        chk("sat_read", rd_data, MAXV);
        chk("sat_cycle", cycle, MAXV);
        chk("sat_ovf", ovf, 5'b00011);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        evt = '0;
        start = 1'b0;
        chk("sat_ovf_clr", ovf, 0);
        chk("s_sat_ovf_clr", s_ovf, 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            start  = ($urandom_range(0, 3) != 0);
            evt    = NEVT'($urandom);
            clear  = ($urandom_range(0, 99) < 2);
            rd_req = $urandom_range(0, 1);
            rd_sel = SW'($urandom);
            if ($urandom_range(0, 99) < 4) begin
                if ($urandom_range(0, 2) == 0) limit = 0;
                else limit = CW'($urandom_range(1, 255));
            end
            if ($urandom_range(0, 999) < 4) pulse_reset();
            tick();
        end

        rd_req = 1'b0;
        start = 1'b0;
        clear = 1'b0;
        tick();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
